// File: rtl/pipe_control_if.sv
// Fetch/hazard control bundle between the Y86-64 pipeline datapath and pipe_control.
interface pipe_control_if;
  // fetch stage
  logic [3:0]  f_icode;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic [1:0]  f_stat;
  // decode stage
  logic [3:0]  D_icode;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  // execute stage
  logic [3:0]  E_icode;
  logic [3:0]  E_dstM;
  logic        e_Cnd;
  // memory stage
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valA;
  logic [1:0]  m_stat;
  // writeback stage
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic [1:0]  W_stat;
  // controller outputs
  logic [63:0] f_pc;
  logic        F_stall;
  logic        D_stall;
  logic        D_bubble;
  logic        E_bubble;
  logic        M_bubble;
  logic        W_stall;
  logic        halted;
  logic [1:0]  cpu_stat;
  logic [31:0] cycle_count;

  modport master (
    output f_icode, f_valC, f_valP, f_stat, D_icode, d_srcA, d_srcB,
           E_icode, E_dstM, e_Cnd, M_icode, M_Cnd, M_valA, m_stat,
           W_icode, W_valM, W_stat,
    input  f_pc, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
           halted, cpu_stat, cycle_count
  );

  modport slave (
    input  f_icode, f_valC, f_valP, f_stat, D_icode, d_srcA, d_srcB,
           E_icode, E_dstM, e_Cnd, M_icode, M_Cnd, M_valA, m_stat,
           W_icode, W_valM, W_stat,
    output f_pc, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
           halted, cpu_stat, cycle_count
  );
endinterface

// File: rtl/pipe_control.sv
// Y86-64 fetch sequencer and hazard controller.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RUN    | normal operation, hazard logic active, cycle counter runs
//   ST_HALTED | non-AOK status reached writeback; pipeline frozen until reset
module pipe_control #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic           clock,
  input  logic           reset_n,
  pipe_control_if.slave  bus
);

  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [1:0] S_AOK    = 2'd0;

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [63:0] pred_pc_q, pred_pc_d;
  logic [1:0]  cpu_stat_q, cpu_stat_d;
  logic [31:0] cycle_count_q, cycle_count_d;

  logic load_use;
  logic ret_pending;
  logic mispredict;
  logic w_err;

  assign load_use = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
                    (bus.E_dstM != R_NONE) &&
                    ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
  assign ret_pending = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) ||
                       (bus.M_icode == I_RET);
  assign mispredict = (bus.E_icode == I_JXX) && !bus.e_Cnd;
  assign w_err      = (bus.W_stat != S_AOK);

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // next state: first faulting writeback freezes the machine for good
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && w_err) state_d = ST_HALTED;
  end

  // outputs: controls are forced quiet while reset is held so the datapath
  // sees a clean fetch of RESET_PC regardless of stale stage contents
  always_comb begin
    bus.f_pc     = pred_pc_q;
    bus.F_stall  = 1'b0;
    bus.D_stall  = 1'b0;
    bus.D_bubble = 1'b0;
    bus.E_bubble = 1'b0;
    bus.M_bubble = 1'b0;
    bus.W_stall  = 1'b0;
    if (!reset_n) begin
      bus.f_pc = RESET_PC;
    end else if (state_q == ST_RUN) begin
      if (bus.M_icode == I_JXX && !bus.M_Cnd) bus.f_pc = bus.M_valA;
      else if (bus.W_icode == I_RET)          bus.f_pc = bus.W_valM;
      bus.F_stall  = load_use || ret_pending;
      bus.D_stall  = load_use;
      bus.D_bubble = mispredict || (ret_pending && !load_use);
      bus.E_bubble = mispredict || load_use;
      bus.M_bubble = (bus.m_stat != S_AOK) || w_err;
      bus.W_stall  = w_err;
    end else begin
      bus.F_stall  = 1'b1;
      bus.D_stall  = 1'b1;
      bus.M_bubble = 1'b1;
      bus.W_stall  = 1'b1;
    end
  end

  assign bus.halted      = (state_q == ST_HALTED);
  assign bus.cpu_stat    = cpu_stat_q;
  assign bus.cycle_count = cycle_count_q;

  // datapath next values: predicted PC, captured status, run-cycle counter
  always_comb begin
    pred_pc_d     = pred_pc_q;
    cpu_stat_d    = cpu_stat_q;
    cycle_count_d = cycle_count_q;
    if (state_q == ST_RUN) begin
      // a faulting fetch holds predPC so nothing is fetched beyond the error
      if (!(load_use || ret_pending) && bus.f_stat == S_AOK) begin
        if (bus.f_icode == I_JXX || bus.f_icode == I_CALL) pred_pc_d = bus.f_valC;
        else                                                pred_pc_d = bus.f_valP;
      end
      if (w_err) cpu_stat_d    = bus.W_stat;
      else       cycle_count_d = cycle_count_q + 32'd1;
    end
  end

  // datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pred_pc_q     <= RESET_PC;
      cpu_stat_q    <= S_AOK;
      cycle_count_q <= 32'd0;
    end else begin
      pred_pc_q     <= pred_pc_d;
      cpu_stat_q    <= cpu_stat_d;
      cycle_count_q <= cycle_count_d;
    end
  end

endmodule

// File: tb/tb_pipe_control.sv
// Directed + random bench for pipe_control against a behavioural model.
module tb_pipe_control;
  localparam logic [63:0] RST_PC = 64'h4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  pipe_control_if bus();

  pipe_control #(.RESET_PC(RST_PC)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  logic [63:0] m_pred;
  logic        m_halted;
  logic [1:0]  m_stat;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    bus.f_icode = 4'h1; bus.f_valC = 64'h0; bus.f_valP = 64'h0; bus.f_stat = 2'd0;
    bus.D_icode = 4'h1; bus.d_srcA = 4'hF; bus.d_srcB = 4'hF;
    bus.E_icode = 4'h1; bus.E_dstM = 4'hF; bus.e_Cnd = 1'b1;
    bus.M_icode = 4'h1; bus.M_Cnd = 1'b1; bus.M_valA = 64'h0; bus.m_stat = 2'd0;
    bus.W_icode = 4'h1; bus.W_valM = 64'h0; bus.W_stat = 2'd0;
  endtask

  // Assert reset asynchronously, check reset values while it is still low,
  // then release at a falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    m_pred = RST_PC; m_halted = 1'b0; m_stat = 2'd0; m_cnt = 32'd0;
    chk("rst_f_pc", bus.f_pc, RST_PC);
    chk("rst_ctrl", {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble,
                     bus.M_bubble, bus.W_stall}, 64'h0);
    chk("rst_halted", bus.halted, 64'h0);
    chk("rst_cpu_stat", bus.cpu_stat, 64'h0);
    chk("rst_cycle_count", bus.cycle_count, 64'h0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Check all outputs against the model for the current inputs, clock once,
  // advance the model, and return at the following falling edge.
  task automatic step();
    logic lu, rp, mp;
    logic [63:0] e_pc, n_pred;
    logic e_fs, e_ds, e_db, e_eb, e_mb, e_ws;
    logic [1:0] n_stat;
    logic n_halted;
    logic [31:0] n_cnt;
    #1;
    lu = (bus.E_icode == 4'h5 || bus.E_icode == 4'hB) && bus.E_dstM != 4'hF &&
         (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
    rp = (bus.D_icode == 4'h9) || (bus.E_icode == 4'h9) || (bus.M_icode == 4'h9);
    mp = (bus.E_icode == 4'h7) && !bus.e_Cnd;
    n_pred = m_pred; n_stat = m_stat; n_halted = m_halted; n_cnt = m_cnt;
    if (m_halted) begin
      e_pc = m_pred;
      {e_fs, e_ds, e_db, e_eb, e_mb, e_ws} = 6'b110011;
    end else begin
      if (bus.M_icode == 4'h7 && !bus.M_Cnd) e_pc = bus.M_valA;
      else if (bus.W_icode == 4'h9)           e_pc = bus.W_valM;
      else                                    e_pc = m_pred;
      e_fs = lu | rp;
      e_ds = lu;
      e_db = mp | (rp & ~lu);
      e_eb = mp | lu;
      e_mb = (bus.m_stat != 0) | (bus.W_stat != 0);
      e_ws = (bus.W_stat != 0);
      if (!e_fs && bus.f_stat == 0)
        n_pred = (bus.f_icode == 4'h7 || bus.f_icode == 4'h8) ? bus.f_valC : bus.f_valP;
      if (bus.W_stat != 0) begin n_halted = 1'b1; n_stat = bus.W_stat; end
      else n_cnt = m_cnt + 1;
    end
    chk("f_pc", bus.f_pc, e_pc);
    chk("F_stall", bus.F_stall, e_fs);
    chk("D_stall", bus.D_stall, e_ds);
    chk("D_bubble", bus.D_bubble, e_db);
    chk("E_bubble", bus.E_bubble, e_eb);
    chk("M_bubble", bus.M_bubble, e_mb);
    chk("W_stall", bus.W_stall, e_ws);
    chk("halted", bus.halted, m_halted);
    chk("cpu_stat", bus.cpu_stat, m_stat);
    chk("cycle_count", bus.cycle_count, m_cnt);
    @(posedge clock);
    m_pred = n_pred; m_stat = n_stat; m_halted = n_halted; m_cnt = n_cnt;
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] cnt_frozen;
    set_idle();
    // stale hazards present while reset is held must not leak to the outputs
    bus.M_icode = 4'h7; bus.M_Cnd = 1'b0; bus.M_valA = 64'h99;
    bus.E_icode = 4'h7; bus.e_Cnd = 1'b0; bus.W_stat = 2'd1;
    do_reset();
    set_idle();

    // first fetch after reset
    bus.f_valP = 64'h5;
    #1 chk("tp_first_pc", bus.f_pc, 64'h4);
    step();
    chk("tp_next_pc", bus.f_pc, 64'h5);
    chk("tp_count1", bus.cycle_count, 64'h1);

    // branch predicted taken, then mispredicted
    bus.f_icode = 4'h7; bus.f_valC = 64'h40; bus.f_valP = 64'h9;
    step();
    chk("tp_pred_taken", bus.f_pc, 64'h40);
    set_idle(); bus.f_valP = 64'h41; bus.E_icode = 4'h7; bus.e_Cnd = 1'b0;
    #1 chk("tp_mp_bubbles", {bus.D_bubble, bus.E_bubble}, 64'h3);
    step();
    set_idle(); bus.f_valP = 64'h42; bus.M_icode = 4'h7; bus.M_Cnd = 1'b0; bus.M_valA = 64'h9;
    #1 chk("tp_mp_redirect", bus.f_pc, 64'h9);
    step();

    // load/use hazard, then same with no destination
    set_idle(); bus.f_valP = 64'h77; bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcB = 4'h3;
    #1 chk("tp_lu_ctrl", {bus.F_stall, bus.D_stall, bus.E_bubble, bus.D_bubble}, 64'hE);
    step();
    step();
    bus.E_dstM = 4'hF;
    #1 chk("tp_lu_none", {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble,
                           bus.M_bubble, bus.W_stall}, 64'h0);
    step();

    // return walking through D, E, M then redirect from W
    set_idle(); bus.D_icode = 4'h9; step();
    set_idle(); bus.E_icode = 4'h9; step();
    set_idle(); bus.M_icode = 4'h9;
    #1 chk("tp_ret_m", {bus.F_stall, bus.D_bubble}, 64'h3);
    step();
    set_idle(); bus.f_valP = 64'h108; bus.W_icode = 4'h9; bus.W_valM = 64'h100;
    #1 chk("tp_ret_redirect", bus.f_pc, 64'h100);
    step();

    // redirect priority: mispredict in M beats ret in W
    set_idle(); bus.M_icode = 4'h7; bus.M_Cnd = 1'b0; bus.M_valA = 64'h55;
    bus.W_icode = 4'h9; bus.W_valM = 64'h200;
    #1 chk("tp_redirect_prio", bus.f_pc, 64'h55);
    step();

    // fetch error holds predPC; combined mispredict + ret
    set_idle(); bus.f_stat = 2'd2; bus.f_valP = 64'hDEAD; step(); step();
    set_idle(); bus.E_icode = 4'h7; bus.e_Cnd = 1'b0; bus.D_icode = 4'h9;
    #1 chk("tp_mp_ret", {bus.D_bubble, bus.E_bubble, bus.F_stall}, 64'h7);
    step();

    // load/use together with ret pending
    set_idle(); bus.E_icode = 4'hB; bus.E_dstM = 4'h2; bus.d_srcA = 4'h2; bus.M_icode = 4'h9;
    #1 chk("tp_lu_ret", {bus.D_stall, bus.D_bubble}, 64'h2);
    step();

    // halt on writeback status, frozen afterwards, async reset out of it
    set_idle(); bus.f_valP = 64'h300; bus.W_stat = 2'd1;
    #1 chk("tp_halt_same_cycle", {bus.W_stall, bus.M_bubble}, 64'h3);
    cnt_frozen = m_cnt;
    step();
    chk("tp_halted", bus.halted, 64'h1);
    chk("tp_halt_stat", bus.cpu_stat, 64'h1);
    set_idle(); bus.f_icode = 4'h7; bus.f_valC = 64'h999; bus.W_stat = 2'd3;
    bus.E_icode = 4'h7; bus.e_Cnd = 1'b0; bus.W_icode = 4'h9; bus.W_valM = 64'h777;
    step(); step(); step();
    chk("tp_count_frozen", bus.cycle_count, cnt_frozen);
    #2 reset_n = 1'b0;
    #1 chk("tp_async_rst_halted", bus.halted, 64'h0);
    chk("tp_async_rst_pc", bus.f_pc, RST_PC);
    do_reset();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.f_icode = 4'($urandom_range(0, 15));
      bus.f_valC  = {$urandom, $urandom};
      bus.f_valP  = {$urandom, $urandom};
      bus.f_stat  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      bus.D_icode = 4'($urandom_range(0, 15));
      bus.d_srcA  = 4'($urandom_range(12, 15));
      bus.d_srcB  = 4'($urandom_range(12, 15));
      bus.E_icode = ($urandom_range(0, 2) == 0) ? 4'h5 : 4'($urandom_range(0, 15));
      bus.E_dstM  = 4'($urandom_range(12, 15));
      bus.e_Cnd   = 1'($urandom_range(0, 1));
      bus.M_icode = 4'($urandom_range(0, 15));
      bus.M_Cnd   = 1'($urandom_range(0, 1));
      bus.M_valA  = {$urandom, $urandom};
      bus.m_stat  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      bus.W_icode = 4'($urandom_range(0, 15));
      bus.W_valM  = {$urandom, $urandom};
      bus.W_stat  = ($urandom_range(0, 49) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      if (m_halted && $urandom_range(0, 7) == 0) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end
endmodule

// File: doc/pipe_control.md
# pipe_control

Fetch-stage sequencer and hazard controller for the Y86-64 pipelined processor. It owns the predicted-PC register and drives the fetch unit's PC input each cycle, selecting among predicted PC, mispredicted-branch fallthrough and return address. From decode, execute, memory and writeback stage fields it generates stall and bubble controls for the F/D/E/M/W pipeline registers. A run/halt state machine freezes the pipeline on the first non-AOK writeback status and holds it until reset.

## Interface
- RESET_PC, 64'h0, PC fetched after reset
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- f_icode  in  4  icode from fetch unit
- f_valC  in  64  valC from fetch unit
- f_valP  in  64  valP from fetch unit
- f_stat  in  2  fetch status (0 AOK, 1 HLT, 2 ADR, 3 INS)
- D_icode  in  4  decode-stage icode
- d_srcA, d_srcB  in  4 each  decode source registers (4'hF = none)
- E_icode  in  4  execute-stage icode
- E_dstM  in  4  execute-stage memory destination register
- e_Cnd  in  1  execute-stage branch condition
- M_icode  in  4  memory-stage icode
- M_Cnd  in  1  memory-stage latched condition
- M_valA  in  64  memory-stage valA (jump fallthrough)
- m_stat  in  2  memory-stage status
- W_icode  in  4  writeback-stage icode
- W_valM  in  64  writeback-stage valM (return address)
- W_stat  in  2  writeback-stage status
- f_pc  out  64  PC presented to fetch
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  out  1 each  pipeline-register controls
- halted  out  1  state is HALTED
- cpu_stat  out  2  latched final status, AOK while running
- cycle_count  out  32  cycles spent in RUN

## Operation
- icodes: HALT 0, NOP 1, JXX 7, CALL 8, RET 9, MRMOVQ 5, POPQ B.
- f_pc priority: (M_icode==JXX && !M_Cnd) -> M_valA; else W_icode==RET -> W_valM; else predPC.
- Next predPC: f_icode in {JXX, CALL} -> f_valC; otherwise f_valP.
- load_use = E_icode in {MRMOVQ, POPQ} && E_dstM != 4'hF && (E_dstM==d_srcA || E_dstM==d_srcB).
- ret_pending = RET in {D_icode, E_icode, M_icode}.
- mispredict = E_icode==JXX && !e_Cnd.
- RUN outputs:
  - F_stall = load_use || ret_pending.
  - D_stall = load_use.
  - D_bubble = mispredict || (ret_pending && !load_use).
  - E_bubble = mispredict || load_use.
  - M_bubble = m_stat!=AOK || W_stat!=AOK.
  - W_stall = W_stat!=AOK.
- predPC loads only when RUN, !F_stall and f_stat==AOK. A non-AOK fetch holds predPC, so no fetch runs past an error.
- States: RUN (reset) -> HALTED when W_stat!=AOK is sampled at a rising edge. HALTED is terminal; only reset_n leaves it.
- HALTED outputs: F_stall=D_stall=W_stall=M_bubble=1, D_bubble=E_bubble=0, f_pc=predPC, halted=1, cpu_stat=W_stat captured on entry, predPC and cycle_count frozen.
- cycle_count increments by one each RUN cycle and wraps at 2^32-1 -> 0.

## Timing
- Reset (reset_n low, asynchronous):
  - Registers: predPC=RESET_PC, state=RUN, cpu_stat=0, cycle_count=0.
  - Outputs: f_pc=RESET_PC, halted=0, all stall and bubble outputs 0.
  - Release is synchronous to the next rising edge.
- All stall, bubble and f_pc outputs are combinational from inputs and registers: zero-cycle latency.
- predPC: one-cycle latency. Fetch outputs in cycle n become f_pc in cycle n+1, unless overridden by the f_pc priority.
- W_stall and M_bubble assert in the same cycle W_stat goes non-AOK. halted and cpu_stat update at that cycle's edge. cycle_count does not increment on that edge.
- Simultaneous events:
  - Mispredict plus ret_pending: D_bubble=1, E_bubble=1, F_stall=1.
  - load_use plus ret_pending: D_stall=1, D_bubble=0.
  - Mispredict redirect in M has priority over ret redirect in W.
- Reset asserted mid-HALTED or mid-stall returns to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset with RESET_PC=64'h4, then release; f_icode=1, f_valP=64'h5 -> f_pc=4, then f_pc=5 after one edge; cycle_count=1.
- Branch redirect:
  - f_icode=7, f_valC=64'h40, f_valP=64'h9 -> next f_pc=64'h40.
  - E_icode=7, e_Cnd=0 -> D_bubble=E_bubble=1.
  - Next cycle M_icode=7, M_Cnd=0, M_valA=64'h9 -> f_pc=64'h9.
- Load/use hazard:
  - E_icode=5, E_dstM=3, d_srcB=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0, predPC unchanged across the edge.
  - Repeat with E_dstM=4'hF -> all controls 0.
- Return: D_icode, E_icode, M_icode=9 on successive cycles -> F_stall=D_bubble=1 for 3 cycles; then W_icode=9, W_valM=64'h100 -> f_pc=64'h100.
- Halt: W_stat=1 -> W_stall=M_bubble=1 the same cycle. After the edge: halted=1, cpu_stat=1, cycle_count frozen, f_pc constant. Drop reset_n mid-halt -> halted=0, f_pc=RESET_PC asynchronously.
- Fetch error: f_stat=2 -> predPC held; combined mispredict+ret cycle -> D_bubble=E_bubble=F_stall=1.
